// File: rtl/fp_align_add.sv
// FP32 add/sub front-end: unpack, magnitude swap, align, add/subtract over 3 elastic stages.
// Build option: FPADD_DENORM_EN keeps subnormal operands instead of flushing them to zero.
module fp_align_add #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [EXP_W-1:0]       out_exp,
  output logic [MAN_W+1:0]       out_frac,
  output logic [1:0]             out_special
);

  localparam int unsigned W     = EXP_W + MAN_W + 1;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned SUM_W = MAN_W + 2;

  localparam logic [1:0] SP_NONE = 2'b00;
  localparam logic [1:0] SP_INF  = 2'b01;
  localparam logic [1:0] SP_NAN  = 2'b10;

  // Elastic handshake: a stage loads when empty or when it hands off this cycle.
  logic s1_valid, s2_valid;
  logic s1_en, s2_en, s3_en;

  assign s3_en    = ~out_valid | out_ready;
  assign s2_en    = ~s2_valid | s3_en;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = s1_en;

  // Stage 1 combinational: unpack, classify specials, order operands by magnitude.
  logic             sa, sb_eff, b_gt, eff_sub_c, sign_c;
  logic [EXP_W-1:0] ea, eb, ea_eff, eb_eff, exp_x_c, diff_c;
  logic [MAN_W-1:0] ma, mb;
  logic [SIG_W-1:0] sig_a, sig_b, sig_x_c, sig_y_c;
  logic             a_nan, a_inf, b_nan, b_inf;
  logic [1:0]       special_c;

  always_comb begin
    sa        = a[W-1];
    ea        = a[W-2:MAN_W];
    ma        = a[MAN_W-1:0];
    sb_eff    = b[W-1] ^ op_sub;
    eb        = b[W-2:MAN_W];
    mb        = b[MAN_W-1:0];
    a_nan     = (&ea) & (|ma);
    a_inf     = (&ea) & ~(|ma);
    b_nan     = (&eb) & (|mb);
    b_inf     = (&eb) & ~(|mb);
`ifdef FPADD_DENORM_EN
    ea_eff    = (ea == '0) ? EXP_W'(1) : ea;
    eb_eff    = (eb == '0) ? EXP_W'(1) : eb;
`else
    if (ea == '0) ma = '0;
    if (eb == '0) mb = '0;
    ea_eff    = ea;
    eb_eff    = eb;
`endif
    sig_a     = {(ea != '0), ma};
    sig_b     = {(eb != '0), mb};
    b_gt      = {eb, mb} > {ea, ma};
    eff_sub_c = sa ^ sb_eff;
    if (b_gt) begin
      sig_x_c = sig_b;
      sig_y_c = sig_a;
      exp_x_c = eb_eff;
      diff_c  = eb_eff - ea_eff;
      sign_c  = sb_eff;
    end else begin
      sig_x_c = sig_a;
      sig_y_c = sig_b;
      exp_x_c = ea_eff;
      diff_c  = ea_eff - eb_eff;
      sign_c  = sa;
    end
    special_c = SP_NONE;
    if (a_nan | b_nan) begin
      special_c = SP_NAN;
      sign_c    = 1'b0;
    end else if (a_inf & b_inf) begin
      special_c = eff_sub_c ? SP_NAN : SP_INF;
      sign_c    = eff_sub_c ? 1'b0 : sa;
    end else if (a_inf) begin
      special_c = SP_INF;
      sign_c    = sa;
    end else if (b_inf) begin
      special_c = SP_INF;
      sign_c    = sb_eff;
    end
  end

  logic             s1_sign, s1_eff_sub;
  logic [1:0]       s1_special;
  logic [EXP_W-1:0] s1_exp, s1_diff;
  logic [SIG_W-1:0] s1_sig_x, s1_sig_y;

  // Stage 2 combinational: right-align the smaller significand, truncating shifted-out bits.
  logic [SUM_W-1:0] ysh_c;

  always_comb begin
    ysh_c = '0;
    if (s1_diff < EXP_W'(SUM_W)) ysh_c = {1'b0, s1_sig_y} >> s1_diff;
  end

  logic             s2_sign, s2_eff_sub;
  logic [1:0]       s2_special;
  logic [EXP_W-1:0] s2_exp;
  logic [SIG_W-1:0] s2_sig_x;
  logic [SUM_W-1:0] s2_ysh;

  // Stage 3 combinational: magnitude add/subtract; specials override the datapath.
  logic [SUM_W-1:0] sum_c, frac_c;
  logic [EXP_W-1:0] exp_c;
  logic             osign_c;

  always_comb begin
    sum_c   = s2_eff_sub ? ({1'b0, s2_sig_x} - s2_ysh) : ({1'b0, s2_sig_x} + s2_ysh);
    frac_c  = sum_c;
    exp_c   = s2_exp;
    osign_c = (sum_c == '0) ? 1'b0 : s2_sign;
    if (s2_special != SP_NONE) begin
      frac_c  = '0;
      exp_c   = '1;
      osign_c = s2_sign;
    end
  end

  // Valids and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid   <= 1'b0;
      out_sign    <= 1'b0;
      out_exp     <= '0;
      out_frac    <= '0;
      out_special <= SP_NONE;
    end else begin
      if (s1_en) s1_valid <= in_valid;
      if (s2_en) s2_valid <= s1_valid;
      if (s3_en) out_valid <= s2_valid;
      if (s3_en && s2_valid) begin
        out_sign    <= osign_c;
        out_exp     <= exp_c;
        out_frac    <= frac_c;
        out_special <= s2_special;
      end
    end
  end

  // Internal stage payloads need no reset; they are qualified by the valids.
  always_ff @(posedge clk) begin
    if (s1_en && in_valid) begin
      s1_sign    <= sign_c;
      s1_eff_sub <= eff_sub_c;
      s1_special <= special_c;
      s1_exp     <= exp_x_c;
      s1_diff    <= diff_c;
      s1_sig_x   <= sig_x_c;
      s1_sig_y   <= sig_y_c;
    end
    if (s2_en && s1_valid) begin
      s2_sign    <= s1_sign;
      s2_eff_sub <= s1_eff_sub;
      s2_special <= s1_special;
      s2_exp     <= s1_exp;
      s2_sig_x   <= s1_sig_x;
      s2_ysh     <= ysh_c;
    end
  end

endmodule
